ufifo_txarb: RTL and testbench
==============================

# ufifo_txarb

Packet-atomic round-robin arbiter that lets up to NREQ byte-stream sources share one transmit `ufifo` ahead of the UART transmitter. It grants one requester at a time and holds the grant until that requester's last byte. It forwards bytes one per clock, but only while the FIFO has room, using the FIFO's reported free-slot count plus a local one-write credit. A grant whose requester stalls mid-packet is broken by a watchdog.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `BW`, 8: data width
- `LGFLEN`, 4: log2 of the downstream FIFO length; width of the space input
- `STALLMAX`, 255: idle cycles allowed inside a packet before abort, 1..255

- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; synchronous, active-high; clock i_clk
- `i_req`  in  NREQ  per-requester byte valid; held with data until accepted
- `i_data`  in  NREQ*BW  requester k data in bits [k*BW +: BW]
- `i_last`  in  NREQ  qualifies the byte as the final byte of its packet
- `o_ack`  out  NREQ  combinational ready; a byte transfers when `i_req[k] && o_ack[k]`
- `o_grant`  out  NREQ  one-hot current owner; 0 when idle
- `i_fifo_space`  in  LGFLEN  free slots; the FIFO's fill field in TX mode
- `o_fifo_wr`  out  1  registered FIFO write strobe
- `o_fifo_data`  out  BW  registered FIFO write data
- `o_abort`  out  1  one-cycle pulse when the watchdog breaks a grant
- `o_busy`  out  1  high in XFER state

## Operation
- State machine, two states:
  - IDLE: `o_grant`=0, `o_ack`=0. If any `i_req` bit is set, pick the first requester at or after `ptr` (wrapping modulo NREQ), set `o_grant`, and go to XFER.
  - XFER: `o_ack[g] = space_ok`; all other ack bits are 0.
- Space check:
  - `space_ok = (i_fifo_space > {0,o_fifo_wr})`.
  - The FIFO status lags a write by one clock, so a write in flight consumes one credit.
- Accepted byte:
  - Next cycle `o_fifo_wr`=1 and `o_fifo_data` = that byte; otherwise `o_fifo_wr`=0 and `o_fifo_data` holds.
- Accepted byte with `i_last[g]` set:
  - Set `ptr = g+1` (mod NREQ), clear `o_grant`, go to IDLE.
- Watchdog:
  - An 8-bit counter clears on every accepted byte and on entry to XFER.
  - It increments each XFER cycle where `i_req[g]`=0. A cycle with `i_req[g]`=1 but `space_ok`=0 is backpressure and does not count.
  - When the count reaches STALLMAX: pulse `o_abort`, set `ptr = g+1`, go to IDLE. The partial packet already in the FIFO stays.
- Requests in IDLE from non-granted requesters are never acked. `i_data`/`i_last` of non-granted requesters are ignored.

## Timing
- Reset values: state IDLE, `ptr`=0, `o_grant`=0, `o_ack`=0, `o_fifo_wr`=0, `o_fifo_data`=0, `o_abort`=0, `o_busy`=0, watchdog=0.
- Reset mid-packet drops the grant immediately. No further FIFO write is issued.
- Grant latency: `i_req` seen in IDLE at cycle t gives `o_grant` and `o_ack` valid at t+1. The first FIFO write happens at t+2.
- Throughput: one byte per clock while `space_ok` holds. There is always exactly one IDLE cycle between packets, including back-to-back packets from different owners.
- With `i_fifo_space`=1 and streaming, acks alternate 1,0,1… because of the in-flight credit. With `i_fifo_space`=0, ack stays 0 indefinitely.
- A single-byte packet (`i_last` on the first byte) returns to IDLE after one XFER cycle.
- Fairness: after owner g finishes or aborts, the search starts at g+1, so each requester waits at most NREQ-1 packets.
- Simultaneous events:
  - Abort threshold reached in the same cycle as an accepted byte: acceptance wins and the watchdog clears.
  - Last byte accepted in the same cycle as a new request arrives: the new request is arbitrated in the following IDLE cycle.

## Structure
- Shared package `ufifo_txarb_pkg`:
  - state enum {IDLE, XFER}
  - `STALLW`=8
  - function computing a one-hot round-robin pick
- One natural sub-module: `ufifo_rrpick`, a combinational round-robin priority encoder.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot grant, index, any.

## Test plan
- Reset, then requester 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), space=15:
  - `o_grant`=4'b0100 at t+1;
  - FIFO writes 0x41,0x42,0x43 on consecutive cycles t+2..t+4;
  - IDLE at t+4.
- All four requesters hold 2-byte packets from reset: grant order 0,1,2,3,0, each separated by one IDLE cycle.
- Requester 1 streaming with `i_fifo_space` held at 1: ack pattern 1,0,1,0. With space=0: no ack and no `o_fifo_wr` for 300 cycles, and no abort.
- Requester 0 sends 1 byte without last, then drops `i_req`, STALLMAX=10:
  - `o_abort` pulses exactly 10 XFER cycles after the drop;
  - the next grant goes to requester 1 if it is requesting.
- `i_rst` asserted mid-packet after 2 of 5 bytes: next cycle `o_grant`=0 and `o_fifo_wr`=0; after release, requester 0 has first priority.
- Single-byte packets alternating from requesters 0 and 3 with `i_last`=1: data order preserved in the FIFO, one write every 2 cycles.

Source files
------------

// File: rtl/ufifo_txarb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ufifo_txarb_pkg
//  Description : Shared types, constants and round-robin helper for the
//                transmit-FIFO arbiter (ufifo_txarb) and its priority
//                encoder (ufifo_rrpick).
//  Revision    : 1.0  initial release
// ============================================================================
package ufifo_txarb_pkg;

    // Arbiter states: waiting for a request, or streaming one owner's packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Width of the stall watchdog counter.
    localparam int STALLW = 8;

    // Largest supported requester count; the helper works on this width.
    localparam int unsigned MAXREQ = 8;

    // One-hot round-robin pick: the first set bit of req at or after ptr,
    // wrapping modulo nreq. Bits at or above nreq are never selected.
    // Returns 0 when no request is set.
    function automatic logic [MAXREQ-1:0] rr_pick_onehot(
        input logic [MAXREQ-1:0] req,
        input logic [2:0]        ptr,
        input int unsigned       nreq
    );
        logic [MAXREQ-1:0] pick;
        logic              found;
        int unsigned       pos;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAXREQ; k++) begin
            // ptr < nreq and k < nreq, so a single wrap subtraction suffices.
            pos = {29'd0, ptr} + k;
            if (pos >= nreq) begin
                pos = pos - nreq;
            end
            if ((k < nreq) && !found && req[pos[2:0]]) begin
                pick[pos[2:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ufifo_rrpick.sv
`default_nettype none
// ============================================================================
//  Module      : ufifo_rrpick
//  Description : Combinational round-robin priority encoder. Selects the
//                first requester at or after the rotating pointer.
//  Revision    : 1.0  initial release
//
//  Ports
//    i_req    in   NREQ  request vector
//    i_ptr    in   PW    index where the search starts
//    o_grant  out  NREQ  one-hot winner (0 when no request)
//    o_idx    out  PW    binary index of the winner
//    o_any    out  1     at least one request is set
// ============================================================================
module ufifo_rrpick
    import ufifo_txarb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    logic [MAXREQ-1:0] w_req_ext;
    logic [2:0]        w_ptr_ext;
    logic [MAXREQ-1:0] w_pick;

    always_comb begin
        w_req_ext             = '0;
        w_req_ext[NREQ-1:0]   = i_req;
        w_ptr_ext             = '0;
        w_ptr_ext[PW-1:0]     = i_ptr;
        w_pick                = rr_pick_onehot(w_req_ext, w_ptr_ext, NREQ);
    end

    // Upper pick bits are always zero; scanning them keeps the encoder simple.
    always_comb begin
        o_idx = '0;
        for (int k = 0; k < int'(MAXREQ); k++) begin
            if (w_pick[k]) begin
                o_idx = PW'(k);
            end
        end
    end

    assign o_grant = w_pick[NREQ-1:0];
    assign o_any   = |i_req;

endmodule
`default_nettype wire

// File: rtl/ufifo_txarb.sv
`default_nettype none
// ============================================================================
//  Module      : ufifo_txarb
//  Description : Packet-atomic round-robin arbiter that lets NREQ byte-stream
//                sources share one transmit FIFO. A grant is held until the
//                owner's last byte; bytes are forwarded one per clock while
//                the FIFO has room. A watchdog breaks a stalled grant.
//  Revision    : 1.0  initial release
//
//  Ports
//    i_clk         in   1        clock
//    i_rst         in   1        synchronous active-high reset
//    i_req         in   NREQ     per-requester byte valid
//    i_data        in   NREQ*BW  requester k data in [k*BW +: BW]
//    i_last        in   NREQ     byte is last of its packet
//    o_ack         out  NREQ     combinational ready to the owner
//    o_grant       out  NREQ     one-hot current owner, 0 when idle
//    i_fifo_space  in   LGFLEN   free FIFO slots (lags writes by one clock)
//    o_fifo_wr     out  1        registered FIFO write strobe
//    o_fifo_data   out  BW       registered FIFO write data
//    o_abort       out  1        one-cycle pulse when a grant is broken
//    o_busy        out  1        high while a grant is held
// ============================================================================
module ufifo_txarb
    import ufifo_txarb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BW       = 8,
    parameter int LGFLEN   = 4,
    parameter int STALLMAX = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*BW-1:0]   i_data,
    input  logic [NREQ-1:0]      i_last,
    output logic [NREQ-1:0]      o_ack,
    output logic [NREQ-1:0]      o_grant,
    input  logic [LGFLEN-1:0]    i_fifo_space,
    output logic                 o_fifo_wr,
    output logic [BW-1:0]        o_fifo_data,
    output logic                 o_abort,
    output logic                 o_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              state_q,     state_d;
    logic [PW-1:0]       ptr_q,       ptr_d;
    logic [PW-1:0]       gidx_q,      gidx_d;
    logic [NREQ-1:0]     grant_q,     grant_d;
    logic [STALLW-1:0]   wdog_q,      wdog_d;
    logic                fifo_wr_q,   fifo_wr_d;
    logic [BW-1:0]       fifo_data_q, fifo_data_d;
    logic                abort_q,     abort_d;

    logic [NREQ-1:0]     w_pick_grant;
    logic [PW-1:0]       w_pick_idx;
    logic                w_pick_any;
    logic                w_space_ok;
    logic                w_req_g;
    logic                w_last_g;
    logic [BW-1:0]       w_data_g;
    logic                w_accept;
    logic [PW-1:0]       w_ptr_next;
    logic [STALLW-1:0]   w_wdog_inc;

    ufifo_rrpick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rrpick (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // The space field does not yet reflect a write issued last cycle, so that
    // write still occupies one of the reported free slots.
    assign w_space_ok = (i_fifo_space > LGFLEN'(fifo_wr_q));

    assign w_req_g    = i_req[gidx_q];
    assign w_last_g   = i_last[gidx_q];
    assign w_data_g   = i_data[gidx_q*BW +: BW];
    assign w_accept   = (state_q == XFER) && w_req_g && w_space_ok;
    assign w_ptr_next = (gidx_q == PW'(NREQ-1)) ? '0 : gidx_q + PW'(1);
    assign w_wdog_inc = wdog_q + STALLW'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        wdog_d      = wdog_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    state_d = XFER;
                    grant_d = w_pick_grant;
                    gidx_d  = w_pick_idx;
                    wdog_d  = '0;
                end
            end
            XFER: begin
                if (w_accept) begin
                    // Acceptance takes precedence over the watchdog.
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = w_data_g;
                    wdog_d      = '0;
                    if (w_last_g) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = w_ptr_next;
                    end
                end else if (!w_req_g) begin
                    // Only an absent owner counts as a stall; a present
                    // owner held off by a full FIFO is not penalised.
                    wdog_d = w_wdog_inc;
                    if (w_wdog_inc == STALLW'(STALLMAX)) begin
                        abort_d = 1'b1;
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = w_ptr_next;
                        wdog_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            wdog_q      <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            wdog_q      <= wdog_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
            abort_q     <= abort_d;
        end
    end

    assign o_ack       = ((state_q == XFER) && w_space_ok) ? grant_q : '0;
    assign o_grant     = grant_q;
    assign o_fifo_wr   = fifo_wr_q;
    assign o_fifo_data = fifo_data_q;
    assign o_abort     = abort_q;
    assign o_busy      = (state_q == XFER);

endmodule
`default_nettype wire

// File: tb/tb_ufifo_txarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ufifo_txarb
//  Description : Self-checking bench for ufifo_txarb. A packet-level model
//                predicts owner, acks, FIFO writes and aborts every cycle;
//                directed scenarios pin timing with literal values, then a
//                randomized phase exercises stalls, backpressure and mixing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ufifo_txarb;

    localparam int NREQ     = 4;
    localparam int BW       = 8;
    localparam int LGFLEN   = 4;
    localparam int STALLMAX = 10;

    logic               clk   = 1'b0;
    logic               rst   = 1'b1;
    logic [NREQ-1:0]    req   = '0;
    logic [NREQ*BW-1:0] data  = '0;
    logic [NREQ-1:0]    last  = '0;
    logic [LGFLEN-1:0]  space = 4'd15;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    grant;
    logic               fwr;
    logic [BW-1:0]      fdata;
    logic               abort;
    logic               busy;

    always #5 clk = ~clk;

    ufifo_txarb #(
        .NREQ     (NREQ),
        .BW       (BW),
        .LGFLEN   (LGFLEN),
        .STALLMAX (STALLMAX)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_data       (data),
        .i_last       (last),
        .o_ack        (ack),
        .o_grant      (grant),
        .i_fifo_space (space),
        .o_fifo_wr    (fwr),
        .o_fifo_data  (fdata),
        .o_abort      (abort),
        .o_busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-requester byte sources: {last, data}
    logic [8:0] srcq [NREQ][$];
    bit         pause [NREQ];
    logic [NREQ-1:0] acc_seen = '0;

    // Observation logs for literal checks
    logic [7:0] wlog [$];
    int         wcyc [$];
    int         glog [$];
    int         gcyc [$];
    logic [NREQ-1:0] prev_grant = '0;

    // Behavioural model: owner index (-1 = none), search start, stall count
    bit         mdl_ok  = 1'b0;
    int         m_own   = -1;
    int         m_ptr   = 0;
    int         m_stall = 0;
    bit         m_wr    = 1'b0;
    logic [7:0] m_data  = '0;
    bit         m_abort = 1'b0;

    int         s2_ord  [5]  = '{0, 1, 2, 3, 0};
    logic [7:0] s2_dat  [10] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h12, 8'h13};
    logic [7:0] s6_dat  [6]  = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
    bit         s3_pat  [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: outputs and inputs are both stable at the falling edge.
    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ea;
        bit              sok;
        bit              found;
        bit              nwr;
        bit              nab;
        int              kk;
        if (mdl_ok) begin
            eg  = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
            sok = (int'(space) > int'(m_wr));
            ea  = sok ? eg : 4'b0;
            chk("grant", grant, eg);
            chk("ack", ack, ea);
            chk("busy", busy, (m_own >= 0));
            chk("fifo_wr", fwr, m_wr);
            chk("fifo_data", fdata, m_data);
            chk("abort", abort, m_abort);
            if (fwr === 1'b1) begin
                wlog.push_back(fdata);
                wcyc.push_back(cyc);
            end
            if ((grant != 0) && (prev_grant == 0)) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (grant[k]) glog.push_back(k);
                end
                gcyc.push_back(cyc);
            end
            prev_grant = grant;
        end
        acc_seen = rst ? '0 : (req & ack);
        // Advance the model by one clock
        if (rst) begin
            m_own   = -1;
            m_ptr   = 0;
            m_stall = 0;
            m_wr    = 1'b0;
            m_data  = '0;
            m_abort = 1'b0;
            mdl_ok  = 1'b1;
        end else if (mdl_ok) begin
            sok = (int'(space) > int'(m_wr));
            nwr = 1'b0;
            nab = 1'b0;
            if (m_own < 0) begin
                found = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    kk = (m_ptr + j) % NREQ;
                    if (!found && req[kk]) begin
                        found   = 1'b1;
                        m_own   = kk;
                        m_stall = 0;
                    end
                end
            end else if (req[m_own] && sok) begin
                nwr     = 1'b1;
                m_data  = data[m_own*8 +: 8];
                m_stall = 0;
                if (last[m_own]) begin
                    m_ptr = (m_own + 1) % NREQ;
                    m_own = -1;
                end
            end else if (!req[m_own]) begin
                m_stall++;
                if (m_stall >= STALLMAX) begin
                    nab   = 1'b1;
                    m_ptr = (m_own + 1) % NREQ;
                    m_own = -1;
                end
            end
            m_wr    = nwr;
            m_abort = nab;
        end
        cyc++;
    end

    // Source driver: hold each head byte until it is seen accepted.
    initial begin : drv
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (acc_seen[k] && (srcq[k].size() > 0)) void'(srcq[k].pop_front());
                if ((srcq[k].size() > 0) && !pause[k]) begin
                    req[k]          = 1'b1;
                    data[k*8 +: 8]  = srcq[k][0][7:0];
                    last[k]         = srcq[k][0][8];
                end else begin
                    req[k]          = 1'b0;
                    data[k*8 +: 8]  = 8'($urandom);
                    last[k]         = 1'($urandom);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int k, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            srcq[k].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'(base + 8'(i))});
        end
    endtask

    function automatic bit src_busy();
        for (int k = 0; k < NREQ; k++) begin
            if (srcq[k].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while ((src_busy() || (grant != 0) || fwr) && (n < budget)) begin
            step();
            n++;
        end
        chk(name, (n >= budget), 0);
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n;
        n = 0;
        while ((grant == 0) && (n < budget)) begin
            step();
            n++;
        end
        chk(name, (n >= budget), 0);
    endtask

    task automatic do_reset();
        for (int k = 0; k < NREQ; k++) begin
            srcq[k].delete();
            pause[k] = 1'b0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin : main
        int  n;
        bit  any_ack;
        bit  any_wr;
        bit  any_ab;

        // ---------------- reset values
        rst = 1'b1;
        repeat (3) step();
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_fifo_wr", fwr, 0);
        chk("rst_fifo_data", fdata, 0);
        chk("rst_abort", abort, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // ---------------- requester 2 sends 0x41,0x42,0x43
        push_pkt(2, 3, 8'h41);
        step();
        chk("s1_pre_grant", grant, 0);
        step();
        chk("s1_grant", grant, 4'b0100);
        chk("s1_ack", ack, 4'b0100);
        step();
        chk("s1_wr0", fwr, 1);
        chk("s1_d0", fdata, 8'h41);
        step();
        chk("s1_d1", fdata, 8'h42);
        step();
        chk("s1_d2", fdata, 8'h43);
        chk("s1_idle_grant", grant, 0);
        chk("s1_idle_busy", busy, 0);
        wait_quiet("s1_drain", 50);

        // ---------------- all four requesters, 2-byte packets
        do_reset();
        wlog.delete(); wcyc.delete(); glog.delete(); gcyc.delete();
        push_pkt(0, 2, 8'h10);
        push_pkt(0, 2, 8'h12);
        push_pkt(1, 2, 8'h20);
        push_pkt(2, 2, 8'h30);
        push_pkt(3, 2, 8'h40);
        wait_quiet("s2_drain", 100);
        chk("s2_ngrants", glog.size(), 5);
        if (glog.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("s2_order%0d", i), glog[i], s2_ord[i]);
            for (int i = 1; i < 5; i++) chk($sformatf("s2_gap%0d", i), gcyc[i] - gcyc[i-1], 3);
        end
        chk("s2_nwrites", wlog.size(), 10);
        if (wlog.size() >= 10) begin
            for (int i = 0; i < 10; i++) chk($sformatf("s2_data%0d", i), wlog[i], s2_dat[i]);
        end

        // ---------------- space=1 alternation, then space=0 stall
        space = 4'd1;
        push_pkt(1, 8, 8'h60);
        wait_grant("s3_grant_wait", 20);
        chk("s3_owner", grant, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s3_ack%0d", i), ack[1], s3_pat[i]);
            step();
        end
        space = 4'd0;
        step();
        step();
        any_ack = 1'b0; any_wr = 1'b0; any_ab = 1'b0;
        repeat (300) begin
            any_ack |= (ack != 0);
            any_wr  |= fwr;
            any_ab  |= abort;
            step();
        end
        chk("s3_noack", any_ack, 0);
        chk("s3_nowr", any_wr, 0);
        chk("s3_noabort", any_ab, 0);
        chk("s3_held", grant, 4'b0010);
        space = 4'd15;
        wait_quiet("s3_drain", 50);

        // ---------------- watchdog abort
        srcq[0].push_back({1'b0, 8'h55});
        wait_grant("s4_grant_wait", 20);
        chk("s4_owner", grant, 4'b0001);
        srcq[1].push_back({1'b1, 8'h66});
        step();
        n = 0;
        while ((abort !== 1'b1) && (n < 40)) begin
            step();
            n++;
        end
        chk("s4_abort_delay", n, STALLMAX);
        chk("s4_abort_grant", grant, 0);
        step();
        chk("s4_abort_pulse", abort, 0);
        chk("s4_next_owner", grant, 4'b0010);
        wait_quiet("s4_drain", 50);

        // ---------------- reset mid-packet
        push_pkt(2, 5, 8'h70);
        wait_grant("s5_grant_wait", 20);
        chk("s5_owner", grant, 4'b0100);
        step();
        step();
        chk("s5_second_byte", fdata, 8'h71);
        rst = 1'b1;
        step();
        chk("s5_rst_grant", grant, 0);
        chk("s5_rst_wr", fwr, 0);
        for (int k = 0; k < NREQ; k++) srcq[k].delete();
        step();
        rst = 1'b0;
        srcq[3].push_back({1'b1, 8'h83});
        srcq[0].push_back({1'b1, 8'h80});
        step();
        step();
        chk("s5_first_after_rst", grant, 4'b0001);
        wait_quiet("s5_drain", 50);

        // ---------------- single-byte packets from 0 and 3
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 3; i++) begin
            srcq[0].push_back({1'b1, 8'(8'hA0 + 8'(i))});
            srcq[3].push_back({1'b1, 8'(8'hB0 + 8'(i))});
        end
        wait_quiet("s6_drain", 60);
        chk("s6_nwrites", wlog.size(), 6);
        if (wlog.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("s6_data%0d", i), wlog[i], s6_dat[i]);
            for (int i = 1; i < 6; i++) chk($sformatf("s6_gap%0d", i), wcyc[i] - wcyc[i-1], 2);
        end

        // ---------------- randomized traffic against the model
        begin
            int pcnt [NREQ];
            for (int k = 0; k < NREQ; k++) pcnt[k] = 0;
            repeat (3000) begin
                for (int k = 0; k < NREQ; k++) begin
                    if ((srcq[k].size() < 12) && ($urandom_range(0, 7) == 0))
                        push_pkt(k, int'($urandom_range(1, 5)), 8'($urandom));
                    if (pcnt[k] > 0) pcnt[k]--;
                    else if ($urandom_range(0, 39) == 0) pcnt[k] = int'($urandom_range(1, 14));
                    pause[k] = (pcnt[k] != 0);
                end
                space = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
                step();
            end
            for (int k = 0; k < NREQ; k++) pause[k] = 1'b0;
            space = 4'd15;
            wait_quiet("rnd_drain", 2000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
